// File: rtl/pipe_scroller.sv
`default_nettype none
// ============================================================================
// Module   : pipe_scroller
// Brief    : Scrolling pipe obstacles with respawn, scoring and speed ramp.
// Revision : 1.0
// ============================================================================
module pipe_scroller #(
    parameter int NUM_PIPES     = 2,
    parameter int X_W           = 11,
    parameter int INIT_X        = 319,
    parameter int SPACING       = 320,
    parameter int SPAWN_X       = 639,
    parameter int Y_MIN         = 120,
    parameter int Y_RANGE_LOG2  = 7,
    parameter int Y_INIT        = 200,
    parameter int SPEED_INIT    = 1,
    parameter int SPEED_MAX     = 4,
    parameter int SPEEDUP_EVERY = 10
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     tick,
    input  logic                     enable,
    input  logic                     restart,
    input  logic [9:0]               random,
    input  logic [X_W-1:0]           bird_x,
    output logic [NUM_PIPES*X_W-1:0] pipe_x,
    output logic [NUM_PIPES*X_W-1:0] pipe_y,
    output logic [9:0]               score,
    output logic                     score_pulse,
    output logic [2:0]               speed
);

    localparam int          PASS_W    = $clog2(NUM_PIPES + 1);
    localparam logic [9:0]  Y_MASK    = 10'((1 << Y_RANGE_LOG2) - 1);
    localparam logic [10:0] SCORE_MAX = 11'd999;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FROZEN = 2'd2;

    function automatic logic [X_W-1:0] init_x(input int idx);
        return X_W'(INIT_X + idx * SPACING);
    endfunction

    logic [1:0] state_q, state_d;
    logic       do_update;

    logic [NUM_PIPES-1:0][X_W-1:0] x_q, x_d;
    logic [NUM_PIPES-1:0][X_W-1:0] y_q, y_d;
    logic [9:0]                    score_q, score_d;
    logic                          pulse_q, pulse_d;
    logic [2:0]                    speed_q, speed_d;
    // Points collected towards the next speed step.
    logic [9:0]                    step_q, step_d;

    logic [PASS_W-1:0] pass_cnt;
    logic [10:0]       score_sum;
    logic [9:0]        score_inc;
    logic [9:0]        step_sum;
    logic [X_W-1:0]    speed_ext;

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (enable)  state_d = S_RUN;
                S_RUN:    if (!enable) state_d = S_FROZEN;
                S_FROZEN: if (enable)  state_d = S_RUN;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        do_update = (state_q == S_RUN) && tick && !restart;
    end

    // ------------------------------------------------------------------------
    // Pipe datapath
    // ------------------------------------------------------------------------
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        score_d   = score_q;
        pulse_d   = 1'b0;
        speed_d   = speed_q;
        step_d    = step_q;
        pass_cnt  = '0;
        score_sum = '0;
        score_inc = '0;
        step_sum  = '0;
        speed_ext = X_W'(speed_q);

        if (restart) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                x_d[i] = init_x(i);
                y_d[i] = X_W'(Y_INIT);
            end
            score_d = '0;
            speed_d = 3'(SPEED_INIT);
            step_d  = '0;
        end else if (do_update) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                if (x_q[i] >= speed_ext) begin
                    x_d[i] = x_q[i] - speed_ext;
                    if ((x_q[i] >= bird_x) && (x_d[i] < bird_x)) begin
                        pass_cnt = pass_cnt + PASS_W'(1);
                    end
                end else begin
                    // Every respawning pipe shares this tick's random sample.
                    x_d[i] = X_W'(SPAWN_X);
                    y_d[i] = X_W'(Y_MIN) + X_W'(random & Y_MASK);
                end
            end

            if (pass_cnt != '0) begin
                pulse_d   = 1'b1;
                score_sum = {1'b0, score_q} + 11'(pass_cnt);
                score_d   = (score_sum > SCORE_MAX) ? SCORE_MAX[9:0] : score_sum[9:0];
                score_inc = score_d - score_q;
                step_sum  = step_q + score_inc;
                if (step_sum >= 10'(SPEEDUP_EVERY)) begin
                    step_d = step_sum - 10'(SPEEDUP_EVERY);
                    if (speed_q < 3'(SPEED_MAX)) begin
                        speed_d = speed_q + 3'd1;
                    end
                end else begin
                    step_d = step_sum;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                x_q[i] <= init_x(i);
                y_q[i] <= X_W'(Y_INIT);
            end
            score_q <= '0;
            pulse_q <= 1'b0;
            speed_q <= 3'(SPEED_INIT);
            step_q  <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            score_q <= score_d;
            pulse_q <= pulse_d;
            speed_q <= speed_d;
            step_q  <= step_d;
        end
    end

    assign pipe_x      = x_q;
    assign pipe_y      = y_q;
    assign score       = score_q;
    assign score_pulse = pulse_q;
    assign speed       = speed_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_scroller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_scroller
// Brief    : Scoreboarded bench for pipe_scroller (default and small geometry).
// Revision : 1.0
// ============================================================================
module tb_pipe_scroller;

    localparam int X_W = 11;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 tick, enable, restart;
    logic [9:0]           random;
    logic [X_W-1:0]       bird_x;
    logic [2*X_W-1:0]     pipe_x, pipe_y;
    logic [9:0]           score;
    logic                 score_pulse;
    logic [2:0]           speed;

    logic                 tick_b, enable_b, restart_b;
    logic [9:0]           random_b;
    logic [X_W-1:0]       bird_x_b;
    logic [2*X_W-1:0]     pipe_x_b, pipe_y_b;
    logic [9:0]           score_b;
    logic                 score_pulse_b;
    logic [2:0]           speed_b;

    int n_checks = 0;
    int n_fail   = 0;
    int sb[$];

    int mx[2], my[2];
    int mscore, mspeed;

    always #5 clk = ~clk;

    pipe_scroller dut (
        .clk(clk), .reset_n(reset_n), .tick(tick), .enable(enable),
        .restart(restart), .random(random), .bird_x(bird_x),
        .pipe_x(pipe_x), .pipe_y(pipe_y), .score(score),
        .score_pulse(score_pulse), .speed(speed)
    );

    // Short lap so the score saturates within a few thousand cycles.
    pipe_scroller #(.INIT_X(8), .SPACING(8), .SPAWN_X(15)) dut_b (
        .clk(clk), .reset_n(reset_n), .tick(tick_b), .enable(enable_b),
        .restart(restart_b), .random(random_b), .bird_x(bird_x_b),
        .pipe_x(pipe_x_b), .pipe_y(pipe_y_b), .score(score_b),
        .score_pulse(score_pulse_b), .speed(speed_b)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mx[0] = 319; mx[1] = 639;
        my[0] = 200; my[1] = 200;
        mscore = 0; mspeed = 1;
    endtask

    task automatic model_step(input int r);
        int p = 0;
        int nx;
        for (int i = 0; i < 2; i++) begin
            if (mx[i] >= mspeed) begin
                nx = mx[i] - mspeed;
                if (mx[i] >= int'(bird_x) && nx < int'(bird_x)) p++;
                mx[i] = nx;
            end else begin
                mx[i] = 639;
                my[i] = 120 + (r % 128);
            end
        end
        if (p > 0) begin
            mscore = (mscore + p > 999) ? 999 : mscore + p;
            sb.push_back(mscore);
            mspeed = (1 + mscore / 10 > 4) ? 4 : 1 + mscore / 10;
        end
    endtask

    task automatic check_model(input string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, " x"}, int'(pipe_x[i*X_W +: X_W]), mx[i]);
            check({tag, " y"}, int'(pipe_y[i*X_W +: X_W]), my[i]);
        end
        check({tag, " score"}, int'(score), mscore);
        check({tag, " speed"}, int'(speed), mspeed);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " x0"}, int'(pipe_x[0 +: X_W]), 319);
        check({tag, " x1"}, int'(pipe_x[X_W +: X_W]), 639);
        check({tag, " y0"}, int'(pipe_y[0 +: X_W]), 200);
        check({tag, " y1"}, int'(pipe_y[X_W +: X_W]), 200);
        check({tag, " score"}, int'(score), 0);
        check({tag, " pulse"}, int'(score_pulse), 0);
        check({tag, " speed"}, int'(speed), 1);
    endtask

    // One tick the DUT is expected to act on; the model advances alongside.
    task automatic do_tick(input int r);
        @(negedge clk);
        tick   = 1'b1;
        random = 10'(r);
        model_step(r);
        @(negedge clk);
        tick   = 1'b0;
    endtask

    task automatic ignored_tick();
        @(negedge clk);
        tick   = 1'b1;
        random = 10'($urandom_range(0, 1023));
        @(negedge clk);
        tick   = 1'b0;
    endtask

    // Scoreboard monitor: every pulse must match the next predicted score.
    always @(negedge clk) begin
        if (score_pulse === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb unexpected pulse: score %0d, none predicted", score);
            end else begin
                check("sb score", int'(score), sb.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        reset_n = 1'b0; tick = 1'b0; enable = 1'b0; restart = 1'b0;
        random = '0; bird_x = '0;
        tick_b = 1'b0; enable_b = 1'b0; restart_b = 1'b0;
        random_b = '0; bird_x_b = '0;
        model_reset();
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Start running; bird at 0 so nothing scores during the first lap.
        @(negedge clk); enable = 1'b1;
        @(negedge clk);
        repeat (319) do_tick($urandom_range(0, 1023));
        check("lap x0", int'(pipe_x[0 +: X_W]), 0);
        check("lap x1", int'(pipe_x[X_W +: X_W]), 320);
        do_tick(10'h3FF);
        check("respawn x0", int'(pipe_x[0 +: X_W]), 639);
        check("respawn y0", int'(pipe_y[0 +: X_W]), 247);
        check("respawn x1", int'(pipe_x[X_W +: X_W]), 319);

        // Bring pipe 1 to the bird and step it past.
        bird_x = 11'd100;
        repeat (219) do_tick($urandom_range(0, 1023));
        check("approach x1", int'(pipe_x[X_W +: X_W]), 100);
        check("approach x0", int'(pipe_x[0 +: X_W]), 420);
        do_tick($urandom_range(0, 1023));
        check("pass x1", int'(pipe_x[X_W +: X_W]), 99);
        check("pass score", int'(score), 1);
        check("pass pulse", int'(score_pulse), 1);
        @(negedge clk);
        check("pulse width", int'(score_pulse), 0);

        // Ten passes lift the speed to 2.
        guard = 0;
        while (mscore < 10 && guard < 4000) begin
            do_tick($urandom_range(0, 1023));
            guard++;
        end
        check("ten passes score", int'(score), 10);
        check("speedup", int'(speed), 2);
        check_model("after ten");
        do_tick($urandom_range(0, 1023));
        check_model("speed2 step");

        // Restart beats a coincident tick, then IDLE ignores a tick.
        @(negedge clk);
        restart = 1'b1; tick = 1'b1; random = 10'd5;
        @(negedge clk);
        restart = 1'b0; enable = 1'b0;
        model_reset();
        check_reset_vals("restart");
        @(negedge clk);
        tick = 1'b0;
        repeat (3) ignored_tick();
        check_reset_vals("idle");

        // Freeze mid-run: bird sits where pipe 0 would cross it.
        @(negedge clk); enable = 1'b1;
        @(negedge clk);
        repeat (30) do_tick($urandom_range(0, 1023));
        check_model("pre freeze");
        @(negedge clk); enable = 1'b0;
        @(negedge clk);
        bird_x = 11'd280;
        repeat (50) ignored_tick();
        check_model("frozen");
        enable = 1'b1;
        @(negedge clk);
        do_tick($urandom_range(0, 1023));
        check_model("resume");
        check("resume x0", int'(pipe_x[0 +: X_W]), 288);

        // Asynchronous reset over a ticking edge leaves no partial update.
        @(negedge clk);
        tick = 1'b1;
        #2 reset_n = 1'b0;
        @(posedge clk); #1;
        model_reset();
        check_reset_vals("async reset");
        @(negedge clk);
        tick = 1'b0; reset_n = 1'b1; enable = 1'b0;

        // Small-geometry instance: saturate at 999 and keep pulsing.
        @(negedge clk);
        enable_b = 1'b1; bird_x_b = 11'd5;
        @(negedge clk);
        tick_b = 1'b1;
        guard = 0;
        while (score_b != 10'd999 && guard < 20000) begin
            @(negedge clk);
            random_b = 10'($urandom_range(0, 1023));
            guard++;
        end
        check("sat reached", int'(score_b), 999);
        check("sat speed", int'(speed_b), 4);
        @(negedge clk);
        guard = 0;
        while (score_pulse_b !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("sat pulse", int'(score_pulse_b), 1);
        check("sat hold", int'(score_b), 999);
        tick_b = 1'b0;

        @(negedge clk);
        check("sb drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
